// File: rtl/interboard_tx_arbiter_pkg.sv
// Shared types for the interboard transmit arbiter: message layout, FSM states,
// message type codes and the round-robin pointer helper.
package interboard_tx_arbiter_pkg;

  localparam int MSG_W = 22;
  localparam int GID_W = 3;

  localparam logic [3:0] MSG_MOVE     = 4'h1;
  localparam logic [3:0] MSG_DRAW     = 4'h2;
  localparam logic [3:0] MSG_END_TURN = 4'h3;
  localparam logic [3:0] MSG_RESET    = 4'h4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} arb_state_t;

  typedef struct packed {
    logic       move_dir;
    logic [4:0] block_x;
    logic [2:0] block_y;
    logic [3:0] msg_type;
    logic [5:0] card;
    logic [2:0] sel_len;
  } msg_t;

  function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] id, input int n);
    return (int'(id) == n - 1) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/interboard_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import interboard_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [GID_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [GID_W-1:0]     ofs;
  int                   sum;

  // Rotate so that bit 0 is the requester at ptr; a plain priority scan then wraps.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    gnt_vld = 1'b0;
    ofs     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req_rot[k]) begin
        gnt_vld = 1'b1;
        ofs     = GID_W'(k);
      end
    end
    sum = int'(ptr) + int'(ofs);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    gnt_idx = GID_W'(sum);
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) gnt[i] = gnt_vld && (gnt_idx == GID_W'(i));
  end

endmodule

// File: rtl/interboard_tx_arbiter.sv
// Shares the interboard transmitter between game-control requesters: one queued
// message per requester, round-robin grant, inter_ready handshake with ack timeout.
module interboard_tx_arbiter
  import interboard_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PAYLOAD_W   = MSG_W,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         interboard_rst,
  input  logic [NUM_REQ-1:0]           req_en,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           req_pending,
  output logic                         req_overflow,
  input  logic                         inter_ready,
  output logic                         ctrl_en,
  output logic                         ctrl_move_dir,
  output logic [4:0]                   ctrl_block_x,
  output logic [2:0]                   ctrl_block_y,
  output logic [3:0]                   ctrl_msg_type,
  output logic [5:0]                   ctrl_card,
  output logic [2:0]                   ctrl_sel_len,
  output logic [GID_W-1:0]             grant_id,
  output logic                         arb_busy,
  output logic                         ack_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] req_pl, slot_q;
  logic [NUM_REQ-1:0]                pending_q, gnt_oh, done_oh;
  logic [GID_W-1:0]                  gnt_idx, rr_ptr;
  logic                              gnt_vld, to_hit, finish;
  logic [PAYLOAD_W-1:0]              gnt_pl;
  logic [CNT_W-1:0]                  to_cnt;
  msg_t                              ctrl_q;
  arb_state_t                        state;

  assign req_pl = req_payload;

  assign to_hit = (state == WAIT_ACK) && inter_ready && (to_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign finish = to_hit || ((state == WAIT_DONE) && inter_ready);

  always_comb begin
    done_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) done_oh[i] = finish && (grant_id == GID_W'(i));
  end

  // Slot i only accepts while empty; its pending bit drops on the finish edge, so a
  // request raised during the matching req_done cycle is captured as a new message.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    logic                 pend;
    logic [PAYLOAD_W-1:0] data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend <= 1'b0;
        data <= '0;
      end else if (interboard_rst) begin
        pend <= 1'b0;
        data <= '0;
      end else if (req_en[i] && !pend) begin
        pend <= 1'b1;
        data <= req_pl[i];
      end else if (done_oh[i]) begin
        pend <= 1'b0;
      end
    end

    assign pending_q[i] = pend;
    assign slot_q[i]    = data;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (pending_q),
    .ptr     (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    gnt_pl = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_oh[i]) gnt_pl = gnt_pl | slot_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      ctrl_q       <= '0;
      ctrl_en      <= 1'b0;
      req_done     <= '0;
      req_overflow <= 1'b0;
      ack_timeout  <= 1'b0;
      to_cnt       <= '0;
    end else if (interboard_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      ctrl_q       <= '0;
      ctrl_en      <= 1'b0;
      req_done     <= '0;
      req_overflow <= 1'b0;
      ack_timeout  <= 1'b0;
      to_cnt       <= '0;
    end else begin
      ctrl_en      <= 1'b0;
      ack_timeout  <= 1'b0;
      req_done     <= done_oh;
      req_overflow <= |(req_en & pending_q);
      if (finish) begin
        rr_ptr <= wrap_inc(grant_id, NUM_REQ);
        state  <= IDLE;
      end
      unique case (state)
        IDLE: if (gnt_vld && inter_ready) begin
          grant_id <= gnt_idx;
          ctrl_q   <= msg_t'(gnt_pl);
          ctrl_en  <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!inter_ready) state <= WAIT_DONE;
          else if (to_hit)  ack_timeout <= 1'b1;
          else              to_cnt <= to_cnt + 1'b1;
        end
        WAIT_DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_pending   = pending_q;
  assign arb_busy      = (state != IDLE);
  assign ctrl_move_dir = ctrl_q.move_dir;
  assign ctrl_block_x  = ctrl_q.block_x;
  assign ctrl_block_y  = ctrl_q.block_y;
  assign ctrl_msg_type = ctrl_q.msg_type;
  assign ctrl_card     = ctrl_q.card;
  assign ctrl_sel_len  = ctrl_q.sel_len;

endmodule

// File: tb/tb_interboard_tx_arbiter.sv
// Directed bench for interboard_tx_arbiter: single request, contention, overflow,
// ack timeout, peer clear, back-to-back request and async reset abort.
module tb_interboard_tx_arbiter;

  localparam int N  = 4;
  localparam int PW = 22;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst, interboard_rst, inter_ready;
  logic [N-1:0]    req_en;
  logic [N*PW-1:0] req_payload;
  logic [N-1:0]    req_done, req_pending;
  logic            req_overflow, ctrl_en, ctrl_move_dir, arb_busy, ack_timeout;
  logic [4:0]      ctrl_block_x;
  logic [2:0]      ctrl_block_y, ctrl_sel_len, grant_id;
  logic [3:0]      ctrl_msg_type;
  logic [5:0]      ctrl_card;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  interboard_tx_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW), .ACK_TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .req_en         (req_en),
    .req_payload    (req_payload),
    .req_done       (req_done),
    .req_pending    (req_pending),
    .req_overflow   (req_overflow),
    .inter_ready    (inter_ready),
    .ctrl_en        (ctrl_en),
    .ctrl_move_dir  (ctrl_move_dir),
    .ctrl_block_x   (ctrl_block_x),
    .ctrl_block_y   (ctrl_block_y),
    .ctrl_msg_type  (ctrl_msg_type),
    .ctrl_card      (ctrl_card),
    .ctrl_sel_len   (ctrl_sel_len),
    .grant_id       (grant_id),
    .arb_busy       (arb_busy),
    .ack_timeout    (ack_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int i, input logic [3:0] t, input logic [5:0] card);
    req_en[i] = 1'b1;
    req_payload[i*PW +: PW] = {1'b1, 5'd9, 3'd5, t, card, 3'd2};
  endtask

  // Entered in the ISSUE cycle; acks the transfer and returns in the req_done cycle.
  task automatic serve(input int id, input logic [5:0] card, input string tag);
    chk({tag, ".en"},   32'(ctrl_en), 32'd1);
    chk({tag, ".gid"},  32'(grant_id), 32'(id));
    chk({tag, ".card"}, 32'(ctrl_card), 32'(card));
    inter_ready = 1'b0;
    step();
    chk({tag, ".en_off"}, 32'(ctrl_en), 32'd0);
    step();
    chk({tag, ".busy"}, 32'(arb_busy), 32'd1);
    inter_ready = 1'b1;
    step();
    chk({tag, ".done"}, 32'(req_done), 32'd1 << id);
    chk({tag, ".hold"}, 32'(ctrl_card), 32'(card));
  endtask

  initial begin
    rst = 1'b1; interboard_rst = 1'b0; inter_ready = 1'b1;
    req_en = '0; req_payload = '0;
    step(); step();
    chk("rst.pending", 32'(req_pending), 32'd0);
    chk("rst.busy",    32'(arb_busy), 32'd0);
    chk("rst.outs",    32'({ctrl_en, req_done, req_overflow, ack_timeout, grant_id}), 32'd0);
    chk("rst.card",    32'(ctrl_card), 32'd0);
    rst = 1'b0;
    step();

    // Single request: ctrl_en two cycles after req_en, done one cycle after ready rises
    req(0, 4'h3, 6'd17);
    step();
    req_en = '0;
    chk("single.pending", 32'(req_pending), 32'h1);
    chk("single.en_early", 32'(ctrl_en), 32'd0);
    step();
    chk("single.en",    32'(ctrl_en), 32'd1);
    chk("single.card",  32'(ctrl_card), 32'd17);
    chk("single.type",  32'(ctrl_msg_type), 32'h3);
    chk("single.xy",    32'({ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_sel_len}), 32'({1'b1, 5'd9, 3'd5, 3'd2}));
    inter_ready = 1'b0;
    step();
    chk("single.en_off", 32'(ctrl_en), 32'd0);
    repeat (4) step();
    chk("single.no_done", 32'(req_done), 32'd0);
    inter_ready = 1'b1;
    step();
    chk("single.done",    32'(req_done), 32'h1);
    chk("single.idle",    32'({arb_busy, req_pending}), 32'd0);
    step();
    chk("single.done_off", 32'(req_done), 32'd0);

    // Peer clear resets the round-robin pointer to 0
    interboard_rst = 1'b1;
    step();
    interboard_rst = 1'b0;
    chk("iclr.card", 32'(ctrl_card), 32'd0);

    // Contention 0,1,3; slot 0 re-requested in its done cycle lands behind 1 and 3
    req(0, 4'h1, 6'd20); req(1, 4'h1, 6'd21); req(3, 4'h1, 6'd23);
    step();
    req_en = '0;
    chk("cont.pending", 32'(req_pending), 32'hB);
    step();
    serve(0, 6'd20, "cont0");
    req(0, 4'h1, 6'd24);
    step();
    req_en = '0;
    chk("cont.reaccept", 32'({req_overflow, req_pending}), 32'h0B);
    serve(1, 6'd21, "cont1");
    step();
    serve(3, 6'd23, "cont3");
    step();
    serve(0, 6'd24, "cont0b");

    // Overflow while transmitter busy; first payload wins
    inter_ready = 1'b0;
    req(2, 4'h2, 6'd33);
    step();
    chk("ovf.first", 32'({req_overflow, req_pending}), 32'h04);
    req(2, 4'h2, 6'd44);
    step();
    req_en = '0;
    chk("ovf.pulse", 32'({req_overflow, req_pending}), 32'h14);
    chk("ovf.nogrant", 32'(arb_busy), 32'd0);
    step();
    chk("ovf.off", 32'(req_overflow), 32'd0);
    inter_ready = 1'b1;
    step();
    serve(2, 6'd33, "ovf");

    // Ack timeout: ready never drops, done 9 cycles after ctrl_en, then next request
    req(3, 4'h4, 6'd50); req(0, 4'h4, 6'd51);
    step();
    req_en = '0;
    chk("to.pending", 32'(req_pending), 32'h9);
    step();
    chk("to.en",  32'(ctrl_en), 32'd1);
    chk("to.gid", 32'(grant_id), 32'd3);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("to.wait", 32'({ack_timeout, req_done}), 32'd0);
    end
    step();
    chk("to.pulse", 32'({ack_timeout, req_done}), 32'h18);
    step();
    serve(0, 6'd51, "to_next");

    // Peer clear during WAIT_DONE with three slots pending
    req(0, 4'h2, 6'd60); req(1, 4'h2, 6'd61); req(2, 4'h2, 6'd62);
    step();
    req_en = '0;
    step();
    chk("clr.gid", 32'(grant_id), 32'd1);
    inter_ready = 1'b0;
    step(); step();
    chk("clr.busy",    32'(arb_busy), 32'd1);
    chk("clr.pending", 32'(req_pending), 32'h7);
    interboard_rst = 1'b1; inter_ready = 1'b1;
    step();
    interboard_rst = 1'b0;
    chk("clr.state", 32'({arb_busy, req_pending, req_done, grant_id}), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("clr.quiet", 32'({ctrl_en, req_done, req_pending}), 32'd0);
    end

    // Back-to-back request raised in the matching req_done cycle
    req(1, 4'h1, 6'd7);
    step();
    req_en = '0;
    step();
    serve(1, 6'd7, "b2b_a");
    req(1, 4'h1, 6'd8);
    step();
    req_en = '0;
    chk("b2b.accept", 32'({req_overflow, req_pending}), 32'h02);
    step();
    serve(1, 6'd8, "b2b_b");

    // Async reset mid-transfer aborts without done or further strobes
    req(2, 4'h1, 6'd9);
    step();
    req_en = '0;
    step();
    chk("arst.en", 32'(ctrl_en), 32'd1);
    inter_ready = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst.clear", 32'({arb_busy, req_pending, req_done, grant_id}), 32'd0);
    chk("arst.card",  32'(ctrl_card), 32'd0);
    step();
    rst = 1'b0; inter_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("arst.quiet", 32'({ctrl_en, req_done}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
